pulse_meter: RTL

PULSE_METER -- requirements
Module: pulse_meter

---
 rtl/pulse_meter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, period and (optionally) phase of three
// asynchronous pulse trains, in clk cycles, with CW-bit saturating counters.
// Latency: Valid/results appear after the 3rd clk edge following an input rise.
// Backpressure: none; results are one-cycle strobes with held outputs.
// Ports:
//   clk, RST (async active-high)         clock and reset
//   S1..S3                               asynchronous pulse inputs
//   PulseW1..3, Period1..3               last measured high time / period
//   Phase2, Phase3                       ch k rise delay after ch 1 rise
//   Valid1..3, Ovf1..3                   update strobe / saturation flag
// Build option: define PULSE_METER_PHASE_EN to include the phase logic;
// otherwise Phase2/Phase3 are tied to 0.
module pulse_meter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          S1,
  input  logic          S2,
  input  logic          S3,
  output logic [CW-1:0] PulseW1,
  output logic [CW-1:0] PulseW2,
  output logic [CW-1:0] PulseW3,
  output logic [CW-1:0] Period1,
  output logic [CW-1:0] Period2,
  output logic [CW-1:0] Period3,
  output logic [CW-1:0] Phase2,
  output logic [CW-1:0] Phase3,
  output logic          Valid1,
  output logic          Valid2,
  output logic          Valid3,
  output logic          Ovf1,
  output logic          Ovf2,
  output logic          Ovf3
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {ST_WAIT = 1'b0, ST_MEAS = 1'b1} state_t;

  // Two synchronizer stages plus one delay stage for edge detection.
  logic [2:0] w_in;
  logic [2:0] r_sync1, r_sync2, r_dly;
  logic [2:0] w_rise, w_fall;

  assign w_in = {S3, S2, S1};

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_dly;
  assign w_fall = ~r_sync2 & r_dly;

  logic [3*CW-1:0] w_period_all, w_pw_all;
  logic [2:0]      w_valid_all, w_ovf_all;

`ifdef PULSE_METER_PHASE_EN
  // Channel 1 counter state, sampled by channels 2 and 3 at their rise.
  logic [CW-1:0]   w_ref_cnt;
  logic            w_ref_meas;
  logic [2*CW-1:0] w_phase_all;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t        r_state, w_state_nxt;
    logic          w_start, w_capture, w_count, w_width_cap;
    logic [CW-1:0] r_cnt, r_width, r_period, r_pw;
    logic          r_ovf, r_ovf_out, r_valid;

    always_ff @(posedge clk or posedge RST) begin
      if (RST) r_state <= ST_WAIT;
      else     r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_WAIT && w_rise[g]) w_state_nxt = ST_MEAS;
    end

    always_comb begin
      w_start     = (r_state == ST_WAIT) && w_rise[g];
      w_capture   = (r_state == ST_MEAS) && w_rise[g];
      w_count     = (r_state == ST_MEAS) && !w_rise[g];
      w_width_cap = (r_state == ST_MEAS) && w_fall[g];
    end

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        r_cnt     <= '0;
        r_width   <= '0;
        r_period  <= '0;
        r_pw      <= '0;
        r_ovf     <= 1'b0;
        r_ovf_out <= 1'b0;
        r_valid   <= 1'b0;
      end else begin
        r_valid <= w_capture;
        if (w_start) begin
          r_cnt   <= CW'(1);
          r_width <= '0;
          r_ovf   <= 1'b0;
        end else if (w_capture) begin
          r_period  <= r_cnt;
          r_pw      <= r_width;
          r_ovf_out <= r_ovf;
          r_cnt     <= CW'(1);
          r_ovf     <= 1'b0;
        end else if (w_count) begin
          // Saturate; an attempted step past the max marks the period overflowed.
          if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
          else                  r_cnt <= r_cnt + CW'(1);
          // Once overflowed the true high time is unknown, so report the max.
          if (w_width_cap) r_width <= r_ovf ? CNT_MAX : r_cnt;
        end
      end
    end

    assign w_period_all[g*CW +: CW] = r_period;
    assign w_pw_all[g*CW +: CW]     = r_pw;
    assign w_valid_all[g]           = r_valid;
    assign w_ovf_all[g]             = r_ovf_out;

`ifdef PULSE_METER_PHASE_EN
    if (g == 0) begin : g_ref
      assign w_ref_cnt  = r_cnt;
      assign w_ref_meas = (r_state == ST_MEAS);
    end else begin : g_phase
      logic [CW-1:0] r_phase;
      // A same-cycle channel-1 rise means zero delay; its counter still
      // holds the previous period at that point, so it must be masked.
      always_ff @(posedge clk or posedge RST) begin
        if (RST)            r_phase <= '0;
        else if (w_capture) r_phase <= (w_ref_meas && !w_rise[0]) ? w_ref_cnt : '0;
      end
      assign w_phase_all[(g-1)*CW +: CW] = r_phase;
    end
`endif
  end

  assign PulseW1 = w_pw_all[0*CW +: CW];
  assign PulseW2 = w_pw_all[1*CW +: CW];
  assign PulseW3 = w_pw_all[2*CW +: CW];
  assign Period1 = w_period_all[0*CW +: CW];
  assign Period2 = w_period_all[1*CW +: CW];
  assign Period3 = w_period_all[2*CW +: CW];
  assign Valid1  = w_valid_all[0];
  assign Valid2  = w_valid_all[1];
  assign Valid3  = w_valid_all[2];
  assign Ovf1    = w_ovf_all[0];
  assign Ovf2    = w_ovf_all[1];
  assign Ovf3    = w_ovf_all[2];

`ifdef PULSE_METER_PHASE_EN
  assign Phase2 = w_phase_all[0*CW +: CW];
  assign Phase3 = w_phase_all[1*CW +: CW];
`else
  assign Phase2 = '0;
  assign Phase3 = '0;
`endif

endmodule
